l2_word_store: RTL and testbench
================================

// Module: l2_word_store
// PURPOSE
//  Downstream word-level backing store serving the L1 data cache refill/write-through port.
//  - Returns one 32-bit word per read request with one-cycle registered latency, matching the
//    L1 refill pipeline.
//  - Absorbs write-through traffic in a coalescing write buffer that drains to a single-port word RAM.
//  - Generates the L1 clock-enable (busy) and the L1 invalidate-all (flush) pulse on
//    coherence request.
// PARAMETERS
//  N          32   data word width
//  ADDR_W     15   word address width; RAM holds 2**ADDR_W words
//  WBUF_DEPTH 4    write buffer entries (power of 2, >=2)
// PORTS
//  clk            in   1       clock
//  reset          in   1       asynchronous, active-high reset
//  read_request   in   1       L1 refill word read request
//  write_request  in   1       L1 write-through request
//  word_address   in   ADDR_W  word address for read or write
//  write_word     in   N       write data
//  flush_req      in   1       coherence controller: invalidate L1 (level, held until flush_ack)
//  read_word      out  N       registered read data
//  l2_busy        out  1       L1 stall (L1 advances only when 0)
//  l1_flush       out  1       one-cycle invalidate-all pulse to L1
//  flush_ack      out  1       one-cycle pulse, same cycle as l1_flush
// BEHAVIOUR
//  - Reset values:
//    - read_word=0, l2_busy=0, l1_flush=0, flush_ack=0.
//    - Buffer empty; FSM=RUN.
//    - RAM contents are not reset.
//  - Read:
//    - read_request sampled at edge k.
//    - read_word <= youngest matching buffer entry if any, else RAM[word_address], at edge k.
//    - Reads are served in every state, including while busy.
//    - read_word holds its value when no read is requested.
//  - Write accept: write_request at edge k with buffer not full.
//    - If word_address equals the tail (youngest) entry address, overwrite that entry's data.
//      This is coalescing; count is unchanged.
//    - Otherwise push {addr,data}.
//    - Writes arriving while the buffer is full are dropped. Busy timing makes this
//      unreachable from a compliant L1.
//  - Drain: RAM is single-port and reads have priority.
//    - On an edge with no read_request and the buffer non-empty: RAM[head.addr] <= head.data; pop.
//    - Push and pop may occur on the same edge; count is then unchanged.
//  - Simultaneous read and write at one edge: the read sees pre-edge buffer/RAM state.
//    A write arriving at the same edge is not forwarded.
//  - Pointers wrap modulo WBUF_DEPTH. count ranges 0..WBUF_DEPTH.
//  - FSM:
//    - RUN: on flush_req -> DRAIN.
//    - DRAIN: stays while buffer non-empty; drains even under read priority. When empty -> FLUSH.
//    - FLUSH: l1_flush=1 and flush_ack=1 for exactly this cycle -> RUN.
//    - flush_req seen again in RUN after ack starts a new flush.
//  - l2_busy (combinational) = (count >= WBUF_DEPTH-1) | (state != RUN).
//    - Asserting at DEPTH-1 leaves one free slot for the L1 write held in flight.
//    - l2_busy is high in the l1_flush cycle, so L1 sees flush while frozen.
//  - Reset mid-DRAIN or mid-FLUSH: returns to RUN. Buffered writes are discarded; no flush pulse.
//  - Address arithmetic is unsigned ADDR_W bits; no carry out.
// CONFIGURATION
//  - L2_STATS_EN defined: adds ports rd_count, wr_count, coalesce_count (out, 16 bits each).
//    - Each counts accepted reads, accepted writes (pushes plus coalesces), and coalesces.
//    - Reset to 0; saturate at 16'hFFFF.
//  - L2_STATS_EN undefined: these ports and counters do not exist. All other behaviour is identical.
// TESTING
//  1. Preload RAM[0x0120..0x012F]=0xA000+i. Drive a 16-address read sweep, one per cycle ->
//     read_word=0xA000+i one cycle after each address, with no gaps.
//  2. Write 0x00000055 to 0x0010, then read 0x0010 next cycle with no idle cycle -> read_word=0x55
//     (forwarded). After idle cycles, RAM[0x0010]=0x55.
//  3. Write 0x11 to 0x0200 on two consecutive cycles -> count=1, coalesce_count=1
//     (with L2_STATS_EN). RAM[0x0200]=0x11 after drain.
//  4. Send 3 distinct writes (DEPTH=4) while read_request is held high -> l2_busy=1 at count=3.
//     Drop read_request -> three drain cycles, then l2_busy=0.
//  5. Issue flush_req with 2 buffered writes -> l2_busy=1; both drained;
//     then l1_flush=flush_ack=1 for exactly 1 cycle; l2_busy=0 the following cycle.
//  6. Assert reset while in DRAIN with count=2 -> state RUN, count=0, l2_busy=0.
//     No l1_flush ever pulses.

Source files
------------

// File: rtl/l2_word_store.sv
// Word backing store for the L1 refill/write-through port: registered reads, coalescing write
// buffer draining to a single-port RAM, and an L1 flush handshake. `L2_STATS_EN adds counters.
module l2_word_store #(
  parameter int N          = 32,
  parameter int ADDR_W     = 15,
  parameter int WBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_request,
  input  logic              write_request,
  input  logic [ADDR_W-1:0] word_address,
  input  logic [N-1:0]      write_word,
  input  logic              flush_req,
  output logic [N-1:0]      read_word,
  output logic              l2_busy,
  output logic              l1_flush,
  output logic              flush_ack
`ifdef L2_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic [15:0]       coalesce_count
`endif
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(WBUF_DEPTH);
  localparam logic [CW-1:0] C_HIGH = CW'(WBUF_DEPTH - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_FLUSH} state_t;

  state_t            r_state, w_state_nxt;
  logic [PW-1:0]     r_head, r_tail;
  logic [CW-1:0]     r_count;
  logic [ADDR_W-1:0] r_baddr [WBUF_DEPTH];
  logic [N-1:0]      r_bdata [WBUF_DEPTH];
  logic [N-1:0]      r_mem   [2**ADDR_W];
  logic [N-1:0]      r_read_word;

  logic [PW-1:0]     w_tail_idx;
  logic              w_accept, w_coal, w_push, w_pop;
  logic [N-1:0]      w_drain_data;
  logic              w_fwd_hit;
  logic [N-1:0]      w_fwd_data;

  assign w_tail_idx = r_tail - PW'(1);
  assign w_accept   = write_request && (r_count != C_FULL);
  assign w_coal     = w_accept && (r_count != '0) && (r_baddr[w_tail_idx] == word_address);
  assign w_push     = w_accept && !w_coal;
  // DRAIN must make progress even if the frozen L1 keeps a read asserted
  assign w_pop      = (r_count != '0) && (!read_request || (r_state == S_DRAIN));
  // A coalesce into the single entry being popped goes straight to RAM so it is not lost
  assign w_drain_data = (w_coal && (r_count == C_ONE)) ? write_word : r_bdata[r_head];

  // Youngest matching entry wins: later iterations are younger
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if ((CW'(i) < r_count) && (r_baddr[r_head + PW'(i)] == word_address)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_bdata[r_head + PW'(i)];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (flush_req) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_count == '0) w_state_nxt = S_FLUSH;
      S_FLUSH: w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_read_word <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (read_request) r_read_word <= w_fwd_hit ? w_fwd_data : r_mem[word_address];
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers above
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_baddr[r_tail] <= word_address;
      r_bdata[r_tail] <= write_word;
    end
    if (w_coal) r_bdata[w_tail_idx] <= write_word;
    if (w_pop)  r_mem[r_baddr[r_head]] <= w_drain_data;
  end

  assign read_word = r_read_word;
  assign l2_busy   = (r_count >= C_HIGH) || (r_state != S_RUN);
  assign l1_flush  = (r_state == S_FLUSH);
  assign flush_ack = (r_state == S_FLUSH);

`ifdef L2_STATS_EN
  logic [15:0] r_rd_cnt, r_wr_cnt, r_co_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
      r_co_cnt <= '0;
    end else begin
      if (read_request && (r_rd_cnt != 16'hFFFF)) r_rd_cnt <= r_rd_cnt + 16'd1;
      if (w_accept && (r_wr_cnt != 16'hFFFF))     r_wr_cnt <= r_wr_cnt + 16'd1;
      if (w_coal && (r_co_cnt != 16'hFFFF))       r_co_cnt <= r_co_cnt + 16'd1;
    end
  end

  assign rd_count       = r_rd_cnt;
  assign wr_count       = r_wr_cnt;
  assign coalesce_count = r_co_cnt;
`endif

endmodule

// File: tb/tb_l2_word_store.sv
// Bench for l2_word_store: directed scenarios plus randomized traffic against a queue/array model.
module tb_l2_word_store;
  localparam int N = 32, AW = 15, D = 4;

  logic          clk = 1'b0, reset = 1'b1;
  logic          read_request = 1'b0, write_request = 1'b0, flush_req = 1'b0;
  logic [AW-1:0] word_address = '0;
  logic [N-1:0]  write_word = '0;
  logic [N-1:0]  read_word;
  logic          l2_busy, l1_flush, flush_ack;
`ifdef L2_STATS_EN
  logic [15:0]   rd_count, wr_count, coalesce_count;
`endif

  l2_word_store #(.N(N), .ADDR_W(AW), .WBUF_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .read_request(read_request), .write_request(write_request),
    .word_address(word_address), .write_word(write_word), .flush_req(flush_req),
    .read_word(read_word), .l2_busy(l2_busy), .l1_flush(l1_flush), .flush_ack(flush_ack)
`ifdef L2_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count), .coalesce_count(coalesce_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  // Reference model: buffer as a FIFO queue, RAM as a sparse map of known words
  typedef struct { logic [AW-1:0] a; logic [N-1:0] d; } ent_t;
  ent_t            q[$];
  logic [N-1:0]    mm [logic [AW-1:0]];
  int              phase;        // 0 running, 1 draining for flush, 2 flush cycle
  logic [N-1:0]    exp_word;
  bit              exp_known;
  int              m_rd, m_wr, m_co;

  function automatic void model_reset();
    q.delete();
    phase = 0; exp_word = '0; exp_known = 1'b1;
    m_rd = 0; m_wr = 0; m_co = 0;
  endfunction

  function automatic void model_edge();
    int  sz;
    bit  hit, accept, coal, pop;
    sz = q.size();
    if (read_request) begin
      hit = 1'b0;
      for (int i = 0; i < sz; i++)
        if (q[i].a == word_address) begin hit = 1'b1; exp_word = q[i].d; end
      if (hit) exp_known = 1'b1;
      else if (mm.exists(word_address)) begin exp_word = mm[word_address]; exp_known = 1'b1; end
      else exp_known = 1'b0;
      if (m_rd < 65535) m_rd++;
    end
    accept = write_request && (sz < D);
    coal   = accept && (sz > 0) && (q[sz-1].a == word_address);
    if (coal) q[sz-1].d = write_word;
    pop = (sz > 0) && (!read_request || phase == 1);
    if (pop) begin mm[q[0].a] = q[0].d; q.delete(0); end
    if (accept && !coal) q.push_back('{word_address, write_word});
    if (accept && m_wr < 65535) m_wr++;
    if (coal && m_co < 65535) m_co++;
    case (phase)
      0: if (flush_req) phase = 1;
      1: if (sz == 0) phase = 2;
      default: phase = 0;
    endcase
  endfunction

  function automatic logic exp_busy(); return (q.size() >= D - 1) || (phase != 0); endfunction
  function automatic logic exp_fl();   return phase == 2; endfunction

  task automatic step(input logic r, input logic w, input logic [AW-1:0] a,
                      input logic [N-1:0] d, input logic f);
    read_request = r; write_request = w; word_address = a; write_word = d; flush_req = f;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    n_cmp++; if (read_word !== 32'h0) begin n_err++; $display("FAIL reset_read_word: got %h want 0", read_word); end
    n_cmp++; if (l2_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", l2_busy); end
    n_cmp++; if (l1_flush !== 1'b0) begin n_err++; $display("FAIL reset_l1_flush: got %b want 0", l1_flush); end
    n_cmp++; if (flush_ack !== 1'b0) begin n_err++; $display("FAIL reset_flush_ack: got %b want 0", flush_ack); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_read_sweep();
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, AW'(16'h0120 + i), 32'hA000 + i, 1'b0);
    repeat (3) step(1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, AW'(16'h0120 + i), '0, 1'b0);
      n_cmp++;
      if (read_word !== 32'hA000 + i) begin
        n_err++; $display("FAIL sweep[%0d]: got %h want %h", i, read_word, 32'hA000 + i);
      end
    end
  endtask

  task automatic test_forward();
    step(1'b0, 1'b1, AW'(16'h0010), 32'h55, 1'b0);
    step(1'b1, 1'b0, AW'(16'h0010), '0, 1'b0);
    n_cmp++; if (read_word !== 32'h55) begin n_err++; $display("FAIL forward: got %h want 55", read_word); end
    repeat (3) step(1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b1, 1'b0, AW'(16'h0010), '0, 1'b0);
    n_cmp++; if (read_word !== 32'h55) begin n_err++; $display("FAIL forward_ram: got %h want 55", read_word); end
  endtask

  task automatic test_coalesce();
`ifdef L2_STATS_EN
    logic [15:0] co0;
    co0 = coalesce_count;
`endif
    step(1'b1, 1'b1, AW'(16'h0200), 32'h11, 1'b0);
    step(1'b1, 1'b1, AW'(16'h0200), 32'h11, 1'b0);
    n_cmp++; if (read_word !== 32'h11) begin n_err++; $display("FAIL coal_fwd: got %h want 11", read_word); end
    step(1'b1, 1'b1, AW'(16'h0201), 32'h22, 1'b0);
    n_cmp++; if (l2_busy !== 1'b0) begin n_err++; $display("FAIL coal_busy_cnt2: got %b want 0", l2_busy); end
    step(1'b1, 1'b1, AW'(16'h0202), 32'h33, 1'b0);
    n_cmp++; if (l2_busy !== 1'b1) begin n_err++; $display("FAIL coal_busy_cnt3: got %b want 1", l2_busy); end
`ifdef L2_STATS_EN
    n_cmp++;
    if (coalesce_count - co0 !== 16'd1) begin
      n_err++; $display("FAIL coal_count: got %0d want 1", coalesce_count - co0);
    end
`endif
    repeat (4) step(1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b1, 1'b0, AW'(16'h0200), '0, 1'b0);
    n_cmp++; if (read_word !== 32'h11) begin n_err++; $display("FAIL coal_ram: got %h want 11", read_word); end
  endtask

  task automatic test_busy();
    logic [2:0] want;
    want = 3'b100;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, AW'(16'h0400 + i), 32'hB0 + i, 1'b0);
      n_cmp++;
      if (l2_busy !== want[i]) begin n_err++; $display("FAIL busy_fill[%0d]: got %b want %b", i, l2_busy, want[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b0);
      n_cmp++;
      if (l2_busy !== 1'b0) begin n_err++; $display("FAIL busy_drain[%0d]: got %b want 0", i, l2_busy); end
    end
    step(1'b1, 1'b0, AW'(16'h0402), '0, 1'b0);
    n_cmp++; if (read_word !== 32'hB2) begin n_err++; $display("FAIL busy_readback: got %h want b2", read_word); end
  endtask

  task automatic test_flush();
    int acks, cyc;
    bit done;
    step(1'b1, 1'b1, AW'(16'h0500), 32'h5A0, 1'b0);
    step(1'b1, 1'b1, AW'(16'h0501), 32'h5A1, 1'b0);
    acks = 0; done = 1'b0;
    for (cyc = 0; cyc < 20 && !done; cyc++) begin
      step(1'b0, 1'b0, '0, '0, 1'b1);
      n_cmp++;
      if (l2_busy !== 1'b1) begin n_err++; $display("FAIL flush_busy[%0d]: got %b want 1", cyc, l2_busy); end
      if (flush_ack === 1'b1) begin
        acks++; done = 1'b1;
        n_cmp++;
        if (l1_flush !== 1'b1 || cyc != 2) begin
          n_err++; $display("FAIL flush_pulse: l1_flush %b at cycle %0d want 1 at 2", l1_flush, cyc);
        end
      end
    end
    n_cmp++; if (acks != 1) begin n_err++; $display("FAIL flush_timeout: got %0d acks want 1", acks); end
    step(1'b0, 1'b0, '0, '0, 1'b0);
    n_cmp++;
    if ({l2_busy, l1_flush, flush_ack} !== 3'b000) begin
      n_err++; $display("FAIL flush_after: busy/flush/ack %b want 000", {l2_busy, l1_flush, flush_ack});
    end
    step(1'b1, 1'b0, AW'(16'h0501), '0, 1'b0);
    n_cmp++; if (read_word !== 32'h5A1) begin n_err++; $display("FAIL flush_drained: got %h want 5a1", read_word); end
  endtask

  task automatic test_reset_drain();
    step(1'b1, 1'b1, AW'(16'h0600), 32'h600, 1'b0);
    step(1'b1, 1'b1, AW'(16'h0601), 32'h601, 1'b0);
    step(1'b1, 1'b0, AW'(16'h0601), '0, 1'b1);
    n_cmp++; if (l2_busy !== 1'b1) begin n_err++; $display("FAIL rstdrain_busy_pre: got %b want 1", l2_busy); end
    read_request = 1'b0; flush_req = 1'b0;
    #1 reset = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (l2_busy !== 1'b0) begin n_err++; $display("FAIL rstdrain_busy: got %b want 0", l2_busy); end
    n_cmp++; if (read_word !== 32'h0) begin n_err++; $display("FAIL rstdrain_word: got %h want 0", read_word); end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b0);
      n_cmp++;
      if (l1_flush !== 1'b0 || l2_busy !== 1'b0) begin
        n_err++; $display("FAIL rstdrain_quiet[%0d]: l1_flush %b busy %b want 0 0", i, l1_flush, l2_busy);
      end
    end
  endtask

  task automatic test_random();
    logic fl;
    logic [AW-1:0] a;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, AW'(16'h0300 + i), $urandom, 1'b0);
    repeat (3) step(1'b0, 1'b0, '0, '0, 1'b0);
    fl = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!fl && $urandom_range(0, 39) == 0) fl = 1'b1;
      a = AW'(16'h0300 + $urandom_range(0, 7));
      step(1'(($urandom_range(0, 1))), 1'($urandom_range(0, 2) != 0), a, $urandom, fl);
      if (flush_ack === 1'b1) fl = 1'b0;
      n_cmp++;
      if (exp_known && read_word !== exp_word) begin
        n_err++; $display("FAIL rand_read[%0d]: got %h want %h", c, read_word, exp_word);
      end
      n_cmp++;
      if (l2_busy !== exp_busy() || l1_flush !== exp_fl() || flush_ack !== exp_fl()) begin
        n_err++; $display("FAIL rand_ctrl[%0d]: busy/flush/ack %b%b%b want %b%b%b", c,
                          l2_busy, l1_flush, flush_ack, exp_busy(), exp_fl(), exp_fl());
      end
    end
`ifdef L2_STATS_EN
    n_cmp++;
    if (rd_count !== 16'(m_rd) || wr_count !== 16'(m_wr) || coalesce_count !== 16'(m_co)) begin
      n_err++; $display("FAIL stats: got %0d/%0d/%0d want %0d/%0d/%0d",
                        rd_count, wr_count, coalesce_count, m_rd, m_wr, m_co);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_read_sweep();
    test_forward();
    test_coalesce();
    test_busy();
    test_flush();
    test_reset_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
